// File: rtl/bp_mon_pkg.sv
// Shared definitions for the backpressure monitor: FSM state encoding and default widths.
package bp_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_LOW = 2'd1,
    ST_LOW      = 2'd2,
    ST_HIGH     = 2'd3
  } bp_state_e;

  localparam int LEN_WIDTH_DEF  = 16;
  localparam int STAT_WIDTH_DEF = 32;

endpackage

// File: rtl/bp_sat_cnt.sv
// Saturating up-counter with clear, load-to-one and increment controls (priority in that order).
module bp_sat_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clks,
  input  logic             reset,
  input  logic             clr,
  input  logic             load1,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clks or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= ONE;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/bp_mon.sv
// Backpressure observer: measures bp burst length/period, bp and stall cycles, and raises a burst timeout alarm.
module bp_mon
  import bp_mon_pkg::*;
#(
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF,
  parameter int STAT_WIDTH = STAT_WIDTH_DEF
) (
  input  logic                  clks,
  input  logic                  reset,
  input  logic                  bp_in,
  input  logic                  vld_in,
  input  logic                  reg_mon_en_cfg,
  input  logic                  reg_clr_cfg,
  input  logic [LEN_WIDTH-1:0]  reg_bp_timeout_cfg,
  output logic [STAT_WIDTH-1:0] sta_bp_cyc_cnt,
  output logic [STAT_WIDTH-1:0] sta_stall_cyc_cnt,
  output logic [STAT_WIDTH-1:0] sta_bp_burst_cnt,
  output logic [LEN_WIDTH-1:0]  sta_bp_last_len,
  output logic [LEN_WIDTH-1:0]  sta_bp_max_len,
  output logic [LEN_WIDTH-1:0]  sta_bp_last_period,
  output logic                  sta_bp_timeout_pulse,
  output logic                  sta_bp_timeout_alm,
  output logic [1:0]            dbg_state
);

  bp_state_e            state;
  logic                 bp_s;
  logic                 vld_s;
  logic                 per_vld;
  logic                 to_done;
  logic [LEN_WIDTH-1:0] run_cnt;
  logic [LEN_WIDTH-1:0] per_cnt;

  logic en;
  logic measuring;
  logic active;
  logic rise;
  logic fall;
  logic run_inc;
  logic per_inc;
  logic fire;
  logic len_clr;

  always_ff @(posedge clks or posedge reset) begin
    if (reset) begin
      bp_s  <= 1'b0;
      vld_s <= 1'b0;
    end else begin
      bp_s  <= bp_in;
      vld_s <= vld_in;
    end
  end

  // Clear dominates every event, so all event strobes are masked by it here.
  assign en        = reg_mon_en_cfg;
  assign measuring = (state == ST_LOW) || (state == ST_HIGH);
  assign active    = en && !reg_clr_cfg && measuring;
  assign rise      = active && (state == ST_LOW) && bp_s;
  assign fall      = active && (state == ST_HIGH) && !bp_s;
  assign run_inc   = active && (state == ST_HIGH) && bp_s;
  assign per_inc   = active && !rise;
  assign fire      = active && (state == ST_HIGH) && (reg_bp_timeout_cfg != '0) &&
                     (run_cnt == reg_bp_timeout_cfg) && !to_done;
  assign len_clr   = reg_clr_cfg || !en;
  assign dbg_state = state;

  bp_sat_cnt #(.WIDTH(LEN_WIDTH)) u_run_cnt (
    .clks  (clks),
    .reset (reset),
    .clr   (len_clr),
    .load1 (rise),
    .inc   (run_inc),
    .cnt   (run_cnt)
  );

  bp_sat_cnt #(.WIDTH(LEN_WIDTH)) u_per_cnt (
    .clks  (clks),
    .reset (reset),
    .clr   (len_clr),
    .load1 (rise),
    .inc   (per_inc),
    .cnt   (per_cnt)
  );

  bp_sat_cnt #(.WIDTH(STAT_WIDTH)) u_bp_cyc_cnt (
    .clks  (clks),
    .reset (reset),
    .clr   (reg_clr_cfg),
    .load1 (1'b0),
    .inc   (active && bp_s),
    .cnt   (sta_bp_cyc_cnt)
  );

  bp_sat_cnt #(.WIDTH(STAT_WIDTH)) u_stall_cyc_cnt (
    .clks  (clks),
    .reset (reset),
    .clr   (reg_clr_cfg),
    .load1 (1'b0),
    .inc   (active && bp_s && vld_s),
    .cnt   (sta_stall_cyc_cnt)
  );

  bp_sat_cnt #(.WIDTH(STAT_WIDTH)) u_burst_cnt (
    .clks  (clks),
    .reset (reset),
    .clr   (reg_clr_cfg),
    .load1 (1'b0),
    .inc   (rise),
    .cnt   (sta_bp_burst_cnt)
  );

  always_ff @(posedge clks or posedge reset) begin
    if (reset) begin
      state                <= ST_IDLE;
      per_vld              <= 1'b0;
      to_done              <= 1'b0;
      sta_bp_last_len      <= '0;
      sta_bp_max_len       <= '0;
      sta_bp_last_period   <= '0;
      sta_bp_timeout_pulse <= 1'b0;
      sta_bp_timeout_alm   <= 1'b0;
    end else if (reg_clr_cfg) begin
      state                <= en ? ST_WAIT_LOW : ST_IDLE;
      per_vld              <= 1'b0;
      to_done              <= 1'b0;
      sta_bp_last_len      <= '0;
      sta_bp_max_len       <= '0;
      sta_bp_last_period   <= '0;
      sta_bp_timeout_pulse <= 1'b0;
      sta_bp_timeout_alm   <= 1'b0;
    end else if (!en) begin
      // An open burst is dropped: status holds, measurement state restarts.
      state                <= ST_IDLE;
      per_vld              <= 1'b0;
      to_done              <= 1'b0;
      sta_bp_timeout_pulse <= 1'b0;
    end else begin
      sta_bp_timeout_pulse <= fire;
      if (fire) begin
        sta_bp_timeout_alm <= 1'b1;
        to_done            <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          state <= ST_WAIT_LOW;
        end
        ST_WAIT_LOW: begin
          if (!bp_s) state <= ST_LOW;
        end
        ST_LOW: begin
          if (bp_s) begin
            state   <= ST_HIGH;
            per_vld <= 1'b1;
            to_done <= 1'b0;
            if (per_vld) sta_bp_last_period <= per_cnt;
          end
        end
        ST_HIGH: begin
          if (fall) begin
            state           <= ST_LOW;
            sta_bp_last_len <= run_cnt;
            if (run_cnt > sta_bp_max_len) sta_bp_max_len <= run_cnt;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bp_mon.sv
// Directed bench for bp_mon: burst table, pre-existing burst, timeout, stall, saturation, clear/disable/reset.
module tb_bp_mon;

  logic        clks;
  logic        reset;
  logic        bp_in;
  logic        vld_in;
  logic        en;
  logic        clr;
  logic [15:0] cfg;
  logic [3:0]  cfg4;

  logic [31:0] bp_cyc, stall_cyc, burst;
  logic [15:0] last_len, max_len, last_per;
  logic        pulse, alm;
  logic [1:0]  st;

  logic [31:0] bp_cyc4, stall_cyc4, burst4;
  logic [3:0]  last_len4, max_len4, last_per4;
  logic        pulse4, alm4;
  logic [1:0]  st4;

  int checks   = 0;
  int failures = 0;
  int pcount   = 0;

  assign cfg4 = cfg[3:0];

  bp_mon dut (
    .clks(clks), .reset(reset), .bp_in(bp_in), .vld_in(vld_in),
    .reg_mon_en_cfg(en), .reg_clr_cfg(clr), .reg_bp_timeout_cfg(cfg),
    .sta_bp_cyc_cnt(bp_cyc), .sta_stall_cyc_cnt(stall_cyc), .sta_bp_burst_cnt(burst),
    .sta_bp_last_len(last_len), .sta_bp_max_len(max_len), .sta_bp_last_period(last_per),
    .sta_bp_timeout_pulse(pulse), .sta_bp_timeout_alm(alm), .dbg_state(st)
  );

  bp_mon #(.LEN_WIDTH(4)) dut4 (
    .clks(clks), .reset(reset), .bp_in(bp_in), .vld_in(vld_in),
    .reg_mon_en_cfg(en), .reg_clr_cfg(clr), .reg_bp_timeout_cfg(cfg4),
    .sta_bp_cyc_cnt(bp_cyc4), .sta_stall_cyc_cnt(stall_cyc4), .sta_bp_burst_cnt(burst4),
    .sta_bp_last_len(last_len4), .sta_bp_max_len(max_len4), .sta_bp_last_period(last_per4),
    .sta_bp_timeout_pulse(pulse4), .sta_bp_timeout_alm(alm4), .dbg_state(st4)
  );

  // clock / reset
  initial clks = 1'b0;
  always #5 clks = ~clks;

  typedef struct {
    int          hi;
    int          lo;
    logic        vld;
    logic [15:0] e_last;
    logic [15:0] e_max;
    logic [15:0] e_per;
    logic [31:0] e_burst;
    logic [31:0] e_bp;
    logic [31:0] e_stall;
  } burst_vec_t;

  burst_vec_t vec[5];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clks);
      #1;
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bp_cyc"}, bp_cyc, 32'd0);
    chk({tag, "_stall"}, stall_cyc, 32'd0);
    chk({tag, "_burst"}, burst, 32'd0);
    chk({tag, "_last"}, {16'd0, last_len}, 32'd0);
    chk({tag, "_max"}, {16'd0, max_len}, 32'd0);
    chk({tag, "_per"}, {16'd0, last_per}, 32'd0);
    chk({tag, "_pulse"}, {31'd0, pulse}, 32'd0);
    chk({tag, "_alm"}, {31'd0, alm}, 32'd0);
  endtask

  initial begin
    vec[0] = '{5, 7, 1'b0, 16'd5, 16'd5, 16'd0,  32'd1, 32'd5,  32'd0};
    vec[1] = '{3, 4, 1'b1, 16'd3, 16'd5, 16'd12, 32'd2, 32'd8,  32'd3};
    vec[2] = '{9, 2, 1'b1, 16'd9, 16'd9, 16'd7,  32'd3, 32'd17, 32'd12};
    vec[3] = '{1, 2, 1'b0, 16'd1, 16'd9, 16'd11, 32'd4, 32'd18, 32'd12};
    vec[4] = '{2, 5, 1'b1, 16'd2, 16'd9, 16'd3,  32'd5, 32'd20, 32'd14};

    reset = 1'b1; bp_in = 1'b0; vld_in = 1'b0; en = 1'b0; clr = 1'b0; cfg = 16'd0;
    cyc(2);
    chk_zero("rst");
    chk("rst_state", {30'd0, st}, 32'd0);
    reset = 1'b0;

    // burst table: consecutive bursts, each checked after its low phase
    en = 1'b1;
    cyc(3);
    chk("t1_state_low", {30'd0, st}, 32'd2);
    for (int i = 0; i < 5; i++) begin
      bp_in  = 1'b1;
      vld_in = vec[i].vld;
      cyc(vec[i].hi);
      bp_in  = 1'b0;
      vld_in = 1'b0;
      cyc(vec[i].lo);
      chk($sformatf("t1_v%0d_last", i), {16'd0, last_len}, {16'd0, vec[i].e_last});
      chk($sformatf("t1_v%0d_max", i), {16'd0, max_len}, {16'd0, vec[i].e_max});
      chk($sformatf("t1_v%0d_per", i), {16'd0, last_per}, {16'd0, vec[i].e_per});
      chk($sformatf("t1_v%0d_burst", i), burst, vec[i].e_burst);
      chk($sformatf("t1_v%0d_bp", i), bp_cyc, vec[i].e_bp);
      chk($sformatf("t1_v%0d_stall", i), stall_cyc, vec[i].e_stall);
    end

    // burst already high at enable is ignored
    en = 1'b0;
    pulse_clr();
    chk("t2_state_idle", {30'd0, st}, 32'd0);
    bp_in = 1'b1;
    cyc(1);
    en = 1'b1;
    cyc(10);
    chk("t2_wait_low", {30'd0, st}, 32'd1);
    bp_in = 1'b0;
    cyc(3);
    bp_in = 1'b1;
    cyc(4);
    bp_in = 1'b0;
    cyc(3);
    chk("t2_burst", burst, 32'd1);
    chk("t2_last", {16'd0, last_len}, 32'd4);
    chk("t2_bp", bp_cyc, 32'd4);
    chk("t2_per", {16'd0, last_per}, 32'd0);

    // timeout: one pulse at the 8th cycle after bp_in rises, sticky alarm
    cfg = 16'd6;
    pulse_clr();
    cyc(3);
    bp_in = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
      if (pulse) pcount++;
      chk($sformatf("t3_pulse_c%0d", k), {31'd0, pulse}, (k == 8) ? 32'd1 : 32'd0);
    end
    bp_in = 1'b0;
    cyc(3);
    chk("t3_alm_sticky", {31'd0, alm}, 32'd1);
    bp_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      if (pulse) pcount++;
    end
    bp_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      if (pulse) pcount++;
    end
    chk("t3_short_no_pulse", pcount, 32'd1);
    cfg = 16'd10;
    bp_in = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k == 5) cfg = 16'd3;
      cyc(1);
      if (pulse) pcount++;
    end
    bp_in = 1'b0;
    cyc(3);
    chk("t3_lowered_no_pulse", pcount, 32'd1);
    chk("t3_alm_still", {31'd0, alm}, 32'd1);
    cfg = 16'd0;

    // stall counting with alternating vld
    pulse_clr();
    cyc(2);
    bp_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vld_in = (i % 2 == 0);
      cyc(1);
    end
    bp_in  = 1'b0;
    vld_in = 1'b0;
    cyc(3);
    chk("t4_stall", stall_cyc, 32'd4);
    chk("t4_bp", bp_cyc, 32'd8);
    chk("t4_last", {16'd0, last_len}, 32'd8);

    // saturation on the narrow instance
    pulse_clr();
    cyc(2);
    bp_in = 1'b1;
    cyc(20);
    bp_in = 1'b0;
    cyc(3);
    chk("t5_last4_sat", {28'd0, last_len4}, 32'hF);
    chk("t5_max4_sat", {28'd0, max_len4}, 32'hF);
    chk("t5_burst4", burst4, 32'd1);
    chk("t5_last16", {16'd0, last_len}, 32'd20);

    // clear coinciding with a fall
    pulse_clr();
    cyc(2);
    bp_in = 1'b1;
    cyc(4);
    bp_in = 1'b0;
    cyc(1);
    pulse_clr();
    chk_zero("t6_clr_fall");
    chk("t6_state_wait", {30'd0, st}, 32'd1);
    cyc(2);
    bp_in = 1'b1;
    cyc(3);
    bp_in = 1'b0;
    cyc(3);
    chk("t6_last_pre", {16'd0, last_len}, 32'd3);
    // disable mid-burst discards it
    bp_in = 1'b1;
    cyc(4);
    en = 1'b0;
    cyc(1);
    bp_in = 1'b0;
    cyc(3);
    chk("t6_dis_last", {16'd0, last_len}, 32'd3);
    chk("t6_dis_burst", burst, 32'd2);
    chk("t6_dis_bp", bp_cyc, 32'd6);
    chk("t6_dis_state", {30'd0, st}, 32'd0);
    en = 1'b1;
    cyc(4);
    chk("t6_reen_last", {16'd0, last_len}, 32'd3);
    chk("t6_reen_max", {16'd0, max_len}, 32'd3);

    // reset mid-burst
    bp_in = 1'b1;
    cyc(5);
    reset = 1'b1;
    #2;
    chk_zero("t7_rst");
    chk("t7_rst_state", {30'd0, st}, 32'd0);
    cyc(1);
    reset = 1'b0;
    bp_in = 1'b0;
    cyc(4);
    chk("t7_post_burst", burst, 32'd0);
    chk("t7_post_last", {16'd0, last_len}, 32'd0);
    chk("t7_post_state", {30'd0, st}, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
